idac_trim_ctrl: RTL



---
 rtl/idac_pkg.sv | 19 +
 rtl/idac_settle_timer.sv | 65 ++++++
 rtl/idac_trim_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/idac_pkg.sv
// idac_pkg: shared types and constants for the IDAC trim sequencer.
//   CODE_W  width of the coarse (ib) and fine (ibf) IDAC codes
//   IB_RST  coarse code held in reset and in IDLE before the first trim
//   IB_MSB  first successive-approximation trial code
//   trim_state_t  sequencer states
package idac_pkg;

    localparam int CODE_W = 8;
    localparam logic [CODE_W-1:0] IB_RST = 8'h7F;
    localparam logic [CODE_W-1:0] IB_MSB = 8'h80;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COARSE = 2'd1,
        FINE   = 2'd2,
        DONE   = 2'd3
    } trim_state_t;

endpackage

// File: rtl/idac_settle_timer.sv
// idac_settle_timer: per-trial settle counter and comparator decision.
// Optional feature macro: IDAC_TRIM_VOTE_EN (3-sample majority vote).
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   load         start a new trial this edge (code is driven on the same edge)
//   settle_cyc   extra wait cycles for the trial being started
//   cmp          synchronised comparator flag
//   tick         decision edge: the FSM acts on cmp_dec at this edge
//   cmp_dec      comparator decision for the current trial
module idac_settle_timer #(
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic                cmp,
    output logic                tick,
    output logic                cmp_dec
);

`ifdef IDAC_TRIM_VOTE_EN
    // Loading settle_cyc+2 makes the three sample edges land at cnt==2,1,0,
    // i.e. E0+settle+1 .. E0+settle+3. One extra bit holds settle_cyc+2.
    localparam int CNT_W = SETTLE_W + 1;

    logic [CNT_W-1:0] cnt;
    logic [1:0]       vote_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(settle_cyc) + CNT_W'(2);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Free-running history of the last two samples; at the decision edge it
    // holds exactly the two earlier samples of this trial.
    always_ff @(posedge clk) begin
        vote_q <= {vote_q[0], cmp};
    end

    assign tick    = (cnt == '0);
    assign cmp_dec = (vote_q[1] & vote_q[0]) | (vote_q[1] & cmp) | (vote_q[0] & cmp);
`else
    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= settle_cyc;
        end else if (cnt != '0) begin
            cnt <= cnt - SETTLE_W'(1);
        end
    end

    assign tick    = (cnt == '0);
    assign cmp_dec = cmp;
`endif

endmodule

// File: rtl/idac_trim_ctrl.sv
// idac_trim_ctrl: closed-loop trim sequencer for the coarse/fine IDAC.
// Successive approximation on ib, then a linear upward search on ibf.
// Optional feature macro: IDAC_TRIM_VOTE_EN (majority-voted comparator,
// implemented in idac_settle_timer).
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   start        trim request, honoured only in IDLE/DONE
//   settle_cyc   extra wait cycles per trial, latched on accepted start
//   cmp          synchronised comparator flag (1 = IDAC current >= target)
//   busy         trim in progress
//   done         one-cycle pulse on completion
//   fail         range error on the last trim, held until next start
//   ib, ibf      coarse and fine IDAC codes
module idac_trim_ctrl
    import idac_pkg::*;
#(
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SETTLE_W-1:0] settle_cyc,
    input  logic                cmp,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [CODE_W-1:0]   ib,
    output logic [CODE_W-1:0]   ibf
);

    localparam int IDX_W = $clog2(CODE_W);

    trim_state_t         state, state_nxt;
    logic [CODE_W-1:0]   ib_nxt, ibf_nxt;
    logic                fail_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic                done_q;
    logic                load;
    logic                accept;
    logic [SETTLE_W-1:0] settle_q;
    logic [SETTLE_W-1:0] load_val;
    logic                tick;
    logic                cmp_dec;

    assign accept   = start && (state == IDLE || state == DONE);
    // The first trial is loaded on the accepting edge, before settle_q updates.
    assign load_val = accept ? settle_cyc : settle_q;

    idac_settle_timer #(
        .SETTLE_W (SETTLE_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .settle_cyc (load_val),
        .cmp        (cmp),
        .tick       (tick),
        .cmp_dec    (cmp_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ib     <= IB_RST;
            ibf    <= '0;
            fail   <= 1'b0;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ib     <= ib_nxt;
            ibf    <= ibf_nxt;
            fail   <= fail_nxt;
            idx    <= idx_nxt;
            done_q <= (state_nxt == DONE) && (state != DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            settle_q <= settle_cyc;
        end
    end

    always_comb begin
        state_nxt = state;
        ib_nxt    = ib;
        ibf_nxt   = ibf;
        fail_nxt  = fail;
        idx_nxt   = idx;
        load      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = COARSE;
                    ib_nxt    = IB_MSB;
                    ibf_nxt   = '0;
                    fail_nxt  = 1'b0;
                    idx_nxt   = IDX_W'(CODE_W - 1);
                    load      = 1'b1;
                end
            end
            COARSE: begin
                if (tick) begin
                    load = 1'b1;
                    if (cmp_dec) begin
                        ib_nxt[idx] = 1'b0;
                    end
                    if (idx != '0) begin
                        ib_nxt[idx - IDX_W'(1)] = 1'b1;
                        idx_nxt                 = idx - IDX_W'(1);
                    end else begin
                        state_nxt = FINE;
                        ibf_nxt   = '0;
                    end
                end
            end
            FINE: begin
                if (tick) begin
                    if (!cmp_dec) begin
                        if (ibf != '1) begin
                            ibf_nxt = ibf + CODE_W'(1);
                            load    = 1'b1;
                        end else begin
                            fail_nxt  = 1'b1;
                            state_nxt = DONE;
                        end
                    end else begin
                        // Step back to the last code below target; at the
                        // bottom of both ranges the target is unreachable.
                        if (ibf != '0) begin
                            ibf_nxt = ibf - CODE_W'(1);
                        end else begin
                            fail_nxt = (ib == '0);
                        end
                        state_nxt = DONE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == COARSE) || (state == FINE);
        done = done_q;
    end

endmodule
